// File: rtl/inst_fetch_if.sv
// ---------------------------------------------------------------------------
// inst_fetch_if
// Bundle of every handshake/bus signal around the instruction-fetch reader:
//   - PC side     : pc_in, pc_valid, pc_ready
//   - ROM side    : mem_en, mem_addr, mem_rdata (1-cycle read latency)
//   - control     : flush (branch redirect)
//   - decode side : inst_out, inst_pc, inst_valid, inst_ready
// modport master : used by inst_fetch itself (drives pc_ready, mem_*, inst_*)
// modport slave  : used by the surrounding datapath / environment
// ---------------------------------------------------------------------------
interface inst_fetch_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] pc_in;
    logic              pc_valid;
    logic              pc_ready;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              flush;
    logic [DATA_W-1:0] inst_out;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_valid;
    logic              inst_ready;

    modport master (
        input  pc_in, pc_valid, mem_rdata, flush, inst_ready,
        output pc_ready, mem_en, mem_addr, inst_out, inst_pc, inst_valid
    );

    modport slave (
        output pc_in, pc_valid, mem_rdata, flush, inst_ready,
        input  pc_ready, mem_en, mem_addr, inst_out, inst_pc, inst_valid
    );
endinterface

// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
// Instruction-fetch reader between the PC register and decode. Accepts PCs
// over a valid/ready handshake, reads a synchronous ROM (data returns one
// cycle after mem_en) and queues {pc, instruction} in a 3-entry FIFO so that
// decode can stall without losing in-flight reads. flush discards everything
// buffered or in flight.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active low
//   bus        inst_fetch_if.master (PC handshake, ROM port, flush, decode)
//   fetch_cnt  [15:0] pops delivered to decode     (INST_FETCH_PERF_EN only)
//   stall_cnt  [15:0] cycles with pc_valid&&!pc_ready (INST_FETCH_PERF_EN only)
//
// Build option: define INST_FETCH_PERF_EN to add the two wrapping performance
// counters; they are cleared only by rst, never by flush.
// ---------------------------------------------------------------------------
module inst_fetch #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    inst_fetch_if.master bus
`ifdef INST_FETCH_PERF_EN
    ,
    output logic [15:0]  fetch_cnt,
    output logic [15:0]  stall_cnt
`endif
);

    logic [DATA_W-1:0] data_mem_r [3];
    logic [ADDR_W-1:0] pc_mem_r   [3];
    logic [1:0]        rd_ptr_r;
    logic [1:0]        wr_ptr_r;
    logic [1:0]        count_r;
    logic [1:0]        count_nxt_s;
    logic              inflight_r;
    logic [ADDR_W-1:0] inflight_pc_r;
    logic [2:0]        credit_s;
    logic              pc_ready_s;
    logic              accept_s;
    logic              write_s;
    logic              pop_s;
    logic              inst_valid_s;
    logic [DATA_W-1:0] head_data_s;
    logic [ADDR_W-1:0] head_pc_s;

    // Modulo-3 pointer increment (2 wraps to 0).
    function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
        logic [1:0] nxt;
        case (ptr)
            2'd0:    nxt = 2'd1;
            2'd1:    nxt = 2'd2;
            default: nxt = 2'd0;
        endcase
        return nxt;
    endfunction

    // Credit rule: a slot is reserved for the read already in flight, so the
    // FIFO can never be written while full. Only registered state feeds this,
    // which keeps inst_ready off the pc_ready path.
    assign credit_s     = {1'b0, count_r} + {2'b00, inflight_r};
    assign pc_ready_s   = !bus.flush && (credit_s < 3'd3);
    assign accept_s     = bus.pc_valid && pc_ready_s;
    assign write_s      = inflight_r && !bus.flush;
    assign inst_valid_s = (count_r != 2'd0);
    assign pop_s        = inst_valid_s && bus.inst_ready && !bus.flush;

    assign bus.pc_ready   = pc_ready_s;
    assign bus.mem_en     = accept_s;
    assign bus.mem_addr   = bus.pc_in;
    assign bus.inst_out   = head_data_s;
    assign bus.inst_pc    = head_pc_s;
    assign bus.inst_valid = inst_valid_s;

    // Occupancy update: a simultaneous write and pop leaves the count unchanged.
    always_comb begin
        count_nxt_s = count_r;
        if (write_s && !pop_s) begin
            count_nxt_s = count_r + 2'd1;
        end else if (pop_s && !write_s) begin
            count_nxt_s = count_r - 2'd1;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // FIFO head read-out, straight from storage (no bypass from mem_rdata).
    always_comb begin
        head_data_s = '0;
        head_pc_s   = '0;
        case (rd_ptr_r)
            2'd0: begin
                head_data_s = data_mem_r[0];
                head_pc_s   = pc_mem_r[0];
            end
            2'd1: begin
                head_data_s = data_mem_r[1];
                head_pc_s   = pc_mem_r[1];
            end
            2'd2: begin
                head_data_s = data_mem_r[2];
                head_pc_s   = pc_mem_r[2];
            end
            default: begin
                head_data_s = '0;
                head_pc_s   = '0;
            end
        endcase
    end

    // Control state: pointers, occupancy and the single in-flight ROM read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_r      <= 2'd0;
            wr_ptr_r      <= 2'd0;
            count_r       <= 2'd0;
            inflight_r    <= 1'b0;
            inflight_pc_r <= '0;
        end else if (bus.flush) begin
            // Redirect: the read returning now and the one issued last cycle
            // are both dropped; pc_ready is low so nothing new is issued.
            rd_ptr_r   <= 2'd0;
            wr_ptr_r   <= 2'd0;
            count_r    <= 2'd0;
            inflight_r <= 1'b0;
        end else begin
            count_r    <= count_nxt_s;
            inflight_r <= accept_s;
            if (write_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            if (accept_s) begin
                inflight_pc_r <= bus.pc_in;
            end
        end
    end

    // FIFO storage: capture the returning ROM word with its PC tag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                data_mem_r[i] <= '0;
                pc_mem_r[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (write_s && (wr_ptr_r == 2'(i))) begin
                    data_mem_r[i] <= bus.mem_rdata;
                    pc_mem_r[i]   <= inflight_pc_r;
                end
            end
        end
    end

`ifdef INST_FETCH_PERF_EN
    logic [15:0] fetch_cnt_r;
    logic [15:0] stall_cnt_r;

    // Wrapping performance counters; deliberately untouched by flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt_r <= 16'd0;
            stall_cnt_r <= 16'd0;
        end else begin
            if (pop_s) begin
                fetch_cnt_r <= fetch_cnt_r + 16'd1;
            end
            if (bus.pc_valid && !pc_ready_s) begin
                stall_cnt_r <= stall_cnt_r + 16'd1;
            end
        end
    end

    assign fetch_cnt = fetch_cnt_r;
    assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch
// Self-checking bench for inst_fetch. A queue-based reference model tracks
// which PCs are buffered and which read is outstanding; the ROM is modelled
// as ROM[a] = a + 0x1000. Directed table vectors, hand-written multi-cycle
// sequences and random traffic are all checked against it.
// ---------------------------------------------------------------------------
module tb_inst_fetch;
    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    inst_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef INST_FETCH_PERF_EN
    logic [15:0] fetch_cnt;
    logic [15:0] stall_cnt;
`endif

    inst_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus)
`ifdef INST_FETCH_PERF_EN
        ,
        .fetch_cnt (fetch_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [8:0] a);
        return 32'h0000_1000 + {23'd0, a};
    endfunction

    // Synchronous ROM, one cycle of read latency.
    always @(posedge clk) begin
        bus.mem_rdata <= bus.mem_en ? rom(bus.mem_addr) : 32'hDEAD_BEEF;
    end

    // Reference model state
    logic [8:0]  fifo_q[$];   // delivered-to-FIFO PCs, head first
    logic [8:0]  infl_q[$];   // PC whose ROM read is outstanding
    logic [15:0] m_fetch;
    logic [15:0] m_stall;
    int          delivered;

    typedef struct {
        logic       pv;
        logic [8:0] pc;
        logic       ir;
        logic       exp_rdy;
        logic       exp_v;
        logic [8:0] exp_pc;
    } vec_t;
    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        fifo_q.delete();
        infl_q.delete();
        m_fetch = 16'd0;
        m_stall = 16'd0;
    endtask

    function automatic logic model_ready();
        return !bus.flush && ((fifo_q.size() + infl_q.size()) < 3);
    endfunction

    task automatic drive(input logic pv, input logic [8:0] pc, input logic fl, input logic ir);
        @(negedge clk);
        bus.pc_valid   = pv;
        bus.pc_in      = pc;
        bus.flush      = fl;
        bus.inst_ready = ir;
        #1;
    endtask

    task automatic model_check();
        logic rdy;
        rdy = model_ready();
        check("pc_ready", {31'd0, bus.pc_ready}, {31'd0, rdy});
        check("mem_en", {31'd0, bus.mem_en}, {31'd0, bus.pc_valid && rdy});
        if (bus.pc_valid && rdy) check("mem_addr", {23'd0, bus.mem_addr}, {23'd0, bus.pc_in});
        check("inst_valid", {31'd0, bus.inst_valid}, {31'd0, fifo_q.size() != 0});
        if (fifo_q.size() != 0) begin
            check("inst_pc", {23'd0, bus.inst_pc}, {23'd0, fifo_q[0]});
            check("inst_out", bus.inst_out, rom(fifo_q[0]));
        end
    endtask

    // Advance the model across the coming rising edge.
    task automatic model_step();
        logic rdy;
        rdy = model_ready();
        if (bus.pc_valid && !rdy) m_stall = m_stall + 16'd1;
        if (bus.flush) begin
            fifo_q.delete();
            infl_q.delete();
        end else begin
            if (fifo_q.size() != 0 && bus.inst_ready) begin
                void'(fifo_q.pop_front());
                m_fetch = m_fetch + 16'd1;
                delivered++;
            end
            if (infl_q.size() != 0) fifo_q.push_back(infl_q.pop_front());
            if (bus.pc_valid && rdy) infl_q.push_back(bus.pc_in);
        end
    endtask

    task automatic cycle(input logic pv, input logic [8:0] pc, input logic fl, input logic ir);
        drive(pv, pc, fl, ir);
        model_check();
        model_step();
    endtask

    // Watchdog: the run must always terminate.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int rdy_cnt;
        int first_v;
        int n;
        int accepted;
        int base_del;
        logic [8:0] pc;
        logic ir;

        // Backpressure table: inst_ready low, 4 PCs offered, then drain.
        tbl[0] = '{1'b1, 9'h010, 1'b0, 1'b1, 1'b0, 9'h000};
        tbl[1] = '{1'b1, 9'h011, 1'b0, 1'b1, 1'b0, 9'h000};
        tbl[2] = '{1'b1, 9'h012, 1'b0, 1'b1, 1'b1, 9'h010};
        tbl[3] = '{1'b1, 9'h013, 1'b0, 1'b0, 1'b1, 9'h010};
        tbl[4] = '{1'b1, 9'h013, 1'b0, 1'b0, 1'b1, 9'h010};
        tbl[5] = '{1'b1, 9'h013, 1'b1, 1'b0, 1'b1, 9'h010};
        tbl[6] = '{1'b1, 9'h013, 1'b1, 1'b1, 1'b1, 9'h011};
        tbl[7] = '{1'b0, 9'h000, 1'b1, 1'b1, 1'b1, 9'h012};
        tbl[8] = '{1'b0, 9'h000, 1'b1, 1'b1, 1'b1, 9'h013};
        tbl[9] = '{1'b0, 9'h000, 1'b1, 1'b1, 1'b0, 9'h000};

        bus.pc_valid   = 1'b0;
        bus.pc_in      = 9'd0;
        bus.flush      = 1'b0;
        bus.inst_ready = 1'b0;
        delivered      = 0;
        model_reset();

        // Reset state
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
        check("reset_inst_out", bus.inst_out, 32'd0);
        check("reset_inst_pc", {23'd0, bus.inst_pc}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Table-driven backpressure
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].pv, tbl[i].pc, 1'b0, tbl[i].ir);
            model_check();
            check("tbl_pc_ready", {31'd0, bus.pc_ready}, {31'd0, tbl[i].exp_rdy});
            check("tbl_inst_valid", {31'd0, bus.inst_valid}, {31'd0, tbl[i].exp_v});
            if (tbl[i].exp_v) begin
                check("tbl_inst_pc", {23'd0, bus.inst_pc}, {23'd0, tbl[i].exp_pc});
                check("tbl_inst_out", bus.inst_out, 32'h0000_1000 + {23'd0, tbl[i].exp_pc});
            end
            model_step();
        end
`ifdef INST_FETCH_PERF_EN
        drive(1'b0, 9'd0, 1'b0, 1'b0);
        check("perf_stall_bp", {16'd0, stall_cnt}, 32'd3);
        check("perf_fetch_bp", {16'd0, fetch_cnt}, 32'd4);
        model_check();
        model_step();
`endif

        // Streaming 0x000..0x00F back-to-back
        rdy_cnt = 0;
        first_v = -1;
        for (int i = 0; i < 19; i++) begin
            if (i < 16) drive(1'b1, 9'(i), 1'b0, 1'b1);
            else        drive(1'b0, 9'd0, 1'b0, 1'b1);
            if (i < 16 && bus.pc_ready) rdy_cnt++;
            if (first_v < 0 && bus.inst_valid) first_v = i;
            model_check();
            model_step();
        end
        check("stream_ready_cycles", rdy_cnt, 32'd16);
        check("stream_first_valid_cycle", first_v, 32'd2);

        // Flush with count=2, inflight=1
        cycle(1'b1, 9'h020, 1'b0, 1'b0);
        cycle(1'b1, 9'h021, 1'b0, 1'b0);
        cycle(1'b1, 9'h022, 1'b0, 1'b0);
        drive(1'b1, 9'h023, 1'b1, 1'b1);
        check("flush_pc_ready", {31'd0, bus.pc_ready}, 32'd0);
        check("flush_pre_valid", {31'd0, bus.inst_valid}, 32'd1);
        model_check();
        model_step();
        drive(1'b1, 9'h1F0, 1'b0, 1'b1);
        check("flush_next_valid", {31'd0, bus.inst_valid}, 32'd0);
        check("flush_next_ready", {31'd0, bus.pc_ready}, 32'd1);
        model_check();
        model_step();
        drive(1'b0, 9'd0, 1'b0, 1'b1);
        check("flush_dropped", {31'd0, bus.inst_valid}, 32'd0);
        model_check();
        model_step();
        drive(1'b0, 9'd0, 1'b0, 1'b1);
        check("flush_new_valid", {31'd0, bus.inst_valid}, 32'd1);
        check("flush_new_pc", {23'd0, bus.inst_pc}, 32'h1F0);
        check("flush_new_out", bus.inst_out, 32'h0000_11F0);
        model_check();
        model_step();

        // Pointer wrap: 10 fetches with inst_ready toggling
        base_del = delivered;
        accepted = 0;
        n = 0;
        ir = 1'b1;
        while (accepted < 10 && n < 80) begin
            pc = 9'h100 + 9'(accepted);
            drive(1'b1, pc, 1'b0, ir);
            if (bus.pc_ready) accepted++;
            model_check();
            model_step();
            ir = ~ir;
            n++;
        end
        n = 0;
        while ((fifo_q.size() != 0 || infl_q.size() != 0) && n < 20) begin
            cycle(1'b0, 9'd0, 1'b0, 1'b1);
            n++;
        end
        check("wrap_accepted", accepted, 32'd10);
        check("wrap_delivered", delivered - base_del, 32'd10);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 3) != 0, 9'($urandom_range(0, 511)),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
        end

        // Reset mid-fetch with inflight=1
        cycle(1'b0, 9'd0, 1'b1, 1'b0);
        cycle(1'b1, 9'h0AA, 1'b0, 1'b0);
        cycle(1'b1, 9'h0AB, 1'b0, 1'b0);
        @(negedge clk);
        bus.pc_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("midreset_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
        check("midreset_inst_out", bus.inst_out, 32'd0);
        check("midreset_inst_pc", {23'd0, bus.inst_pc}, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 9'h055, 1'b0, 1'b1);
        check("post_reset_ready", {31'd0, bus.pc_ready}, 32'd1);
        model_check();
        model_step();
        for (int i = 0; i < 4; i++) cycle(1'b0, 9'd0, 1'b0, 1'b1);

`ifdef INST_FETCH_PERF_EN
        // Run fetch_cnt to 0xFFFF, then one more pop wraps it
        n = 0;
        while (m_fetch != 16'hFFFF && n < 70000) begin
            cycle(1'b1, 9'(n), 1'b0, 1'b1);
            n++;
        end
        drive(1'b0, 9'd0, 1'b0, 1'b0);
        check("perf_fetch_ffff", {16'd0, fetch_cnt}, 32'h0000_FFFF);
        model_check();
        model_step();
        cycle(1'b0, 9'd0, 1'b0, 1'b1);
        drive(1'b0, 9'd0, 1'b0, 1'b0);
        check("perf_fetch_wrap", {16'd0, fetch_cnt}, {16'd0, m_fetch});
        check("perf_stall_total", {16'd0, stall_cnt}, {16'd0, m_stall});
        model_step();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch reader sitting between the 9-bit PC register and the decode stage of the single-cycle CPU datapath. Accepts PC values over a valid/ready handshake and issues reads to a synchronous instruction ROM with 1-cycle read latency. Returns each instruction word, tagged with its PC, through a 3-entry output FIFO so decode can stall without losing in-flight data. A synchronous flush discards all buffered and in-flight fetches on branch redirect.

## Interface
- ADDR_W, 9, PC / ROM address width
- DATA_W, 32, instruction word width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low
- pc_in  in  ADDR_W  fetch address from PC register
- pc_valid  in  1  pc_in is valid
- pc_ready  out  1  fetch accepted this cycle when pc_valid && pc_ready
- mem_en  out  1  ROM read enable (combinational, = pc_valid && pc_ready)
- mem_addr  out  ADDR_W  ROM address (combinational, = pc_in)
- mem_rdata  in  DATA_W  ROM data, valid the cycle after mem_en
- flush  in  1  drop all buffered and in-flight fetches
- inst_out  out  DATA_W  instruction at FIFO head
- inst_pc  out  ADDR_W  PC of inst_out
- inst_valid  out  1  FIFO non-empty
- inst_ready  in  1  decode consumes head when inst_valid && inst_ready

## Operation
- State: FIFO storage (3 × {ADDR_W, DATA_W}), rd_ptr, wr_ptr (mod 3), count[1:0] (0..3), inflight (1 bit), inflight_pc[ADDR_W-1:0].
- Accept: pc_ready = !flush && (count + inflight < 3). On accept: inflight <= 1, inflight_pc <= pc_in; otherwise inflight <= 0.
- Return: if inflight was 1 and no flush this cycle, write {inflight_pc, mem_rdata} at wr_ptr, wr_ptr advances (2 -> 0).
- Pop: inst_valid && inst_ready and no flush -> rd_ptr advances (2 -> 0).
- Simultaneous write and pop: count unchanged; both pointers advance. Write into a full FIFO cannot occur, guaranteed by the pc_ready credit rule.
- inst_out / inst_pc are driven from storage at rd_ptr; no bypass from mem_rdata. inst_valid = (count != 0).
- flush (highest priority): count <= 0, rd_ptr <= wr_ptr <= 0, inflight <= 0. Any mem_rdata returning this cycle is discarded. pc_ready = 0 and no pop takes effect during the flush cycle.
- No combinational path from inst_ready to pc_ready.

## Timing
- Reset (rst low, asynchronous): count=0, pointers=0, inflight=0, inflight_pc=0, storage=0. Consequently inst_valid=0, inst_out=0, inst_pc=0, and pc_ready=1 once rst is high (unless flush is asserted).
- Reset asserted mid-fetch: the in-flight read is lost and no inst_valid results from it.
- Latency: a PC accepted in cycle N gives inst_valid=1 with that PC/data in cycle N+2 (ROM read in N+1, FIFO write at end of N+1).
- Throughput: 1 fetch/cycle sustained while inst_ready=1 (steady state count=1, inflight=1).
- Backpressure: with inst_ready=0, at most 3 fetches are accepted. pc_ready drops in the cycle where count+inflight reaches 3.
- Ordering: instructions are delivered strictly in accept order.

## Configuration
- INST_FETCH_PERF_EN defined: adds outputs fetch_cnt[15:0] and stall_cnt[15:0], both reset to 0 by rst.
  - fetch_cnt increments on each pop.
  - stall_cnt increments each cycle with pc_valid && !pc_ready.
  - Both counters wrap 16'hFFFF -> 0 and are not cleared by flush.
- INST_FETCH_PERF_EN undefined: the ports and counters are absent, and the remaining behaviour is identical.

## Test plan
- Reset: drive rst low mid-stream with inflight=1 -> inst_valid=0, inst_out=0, inst_pc=0 immediately. After release with pc_valid=1, pc_ready=1.
- Streaming: PCs 0x000..0x00F back-to-back, ROM[a]=a+0x1000, inst_ready=1 -> 16 pc_ready=1 cycles with no gaps. inst_valid is continuous from cycle 2, with inst_pc=0x000.. and inst_out=0x1000.. in order.
- Backpressure: inst_ready=0, pc_valid=1 at PCs 0x010,0x011,0x012,0x013 -> exactly 3 accepted, pc_ready=0 from the 4th cycle. Raising inst_ready delivers 0x010,0x011,0x012, then accepts 0x013.
- Flush: count=2, inflight=1, flush=1 for one cycle -> next cycle inst_valid=0 and the returning mem_rdata is dropped. A PC of 0x1F0 accepted after flush emerges 2 cycles later as the first inst_pc.
- Pointer wrap: 10 fetches with inst_ready toggling 1,0,1,0 -> all 10 delivered in order, none duplicated or missing, and count never exceeds 3.
- Perf (INST_FETCH_PERF_EN): backpressure scenario -> stall_cnt equals the number of pc_valid&&!pc_ready cycles and fetch_cnt=4 after drain. Preloading fetch_cnt=0xFFFF and popping once -> 0x0000.
